// File: rtl/mr_latch_stim_if.sv
// Control/status bundle for the latch stimulus generator.
// The design sits on the slave side; the driver (sequencer or bench) is master.
interface mr_latch_stim_if;
  logic       ena;
  logic       start;
  logic       stop;
  logic [7:0] period;
  logic [7:0] high_time;
  logic [7:0] n_pulses;
  logic       stim_out;
  logic       fb_in;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic [7:0] edge_cnt;
  logic [7:0] err_cnt;

  modport slave (
    input  ena, start, stop, period, high_time, n_pulses, fb_in,
    output stim_out, busy, done, cfg_err, edge_cnt, err_cnt
  );

  modport master (
    output ena, start, stop, period, high_time, n_pulses, fb_in,
    input  stim_out, busy, done, cfg_err, edge_cnt, err_cnt
  );
endinterface

// File: rtl/mr_latch_stim.sv
// Pulse-burst stimulus generator for an analog buffer. It drives stim_out,
// synchronises the returned feedback and compares it against a delayed copy
// of the drive, counting feedback rising edges and mismatch cycles.
module mr_latch_stim #(
  parameter int LAT = 3
) (
  input logic            clk,
  input logic            rst_n,
  mr_latch_stim_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_FLUSH, S_DONE} state_t;

  // Delay line value right after an accepted start: stim_out rises on that edge.
  localparam logic [LAT-1:0] DLY_FIRST = 1;

  state_t         r_state, w_nxt;
  logic [7:0]     r_period, r_high, r_npul;
  logic [7:0]     r_cnt, w_cnt_nxt;
  logic [7:0]     r_pcnt, w_pcnt_nxt;
  logic [1:0]     r_sync;
  logic           r_fb_prev;
  logic [LAT-1:0] r_dly;
  logic           r_stim, r_busy, r_done, r_cfg_err;
  logic [7:0]     r_edge, r_err;
  logic           w_legal, w_accept, w_reject;
  logic           w_fb, w_rise, w_active, w_stim_nxt;

  assign w_fb     = r_sync[1];
  assign w_rise   = w_fb & ~r_fb_prev;
  assign w_active = (r_state == S_HIGH) || (r_state == S_LOW) || (r_state == S_FLUSH);
  assign w_legal  = (bus.period >= 8'd2) && (bus.high_time != 8'd0) &&
                    (bus.high_time < bus.period);
  assign w_accept = (r_state == S_IDLE) && bus.start && w_legal;
  assign w_reject = (r_state == S_IDLE) && bus.start && !w_legal;
  assign w_stim_nxt = (w_nxt == S_HIGH);

  // Next-state and phase/pulse counter updates; stop wins over phase ends.
  always_comb begin
    w_nxt      = r_state;
    w_cnt_nxt  = r_cnt;
    w_pcnt_nxt = r_pcnt;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_nxt      = S_HIGH;
        w_cnt_nxt  = bus.high_time - 8'd1;
        w_pcnt_nxt = '0;
      end
      S_HIGH: begin
        if (bus.stop) begin
          w_nxt     = S_FLUSH;
          w_cnt_nxt = 8'(LAT);
        end else if (r_cnt == 8'd0) begin
          w_nxt     = S_LOW;
          w_cnt_nxt = r_period - r_high - 8'd1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_LOW: begin
        if (bus.stop) begin
          w_nxt     = S_FLUSH;
          w_cnt_nxt = 8'(LAT);
        end else if (r_cnt == 8'd0) begin
          w_pcnt_nxt = r_pcnt + 8'd1;
          if ((r_npul != 8'd0) && (w_pcnt_nxt == r_npul)) begin
            w_nxt     = S_FLUSH;
            w_cnt_nxt = 8'(LAT);
          end else begin
            w_nxt     = S_HIGH;
            w_cnt_nxt = r_high - 8'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      // Loaded with LAT on entry, so FLUSH lasts LAT+1 cycles.
      S_FLUSH: begin
        if (r_cnt == 8'd0) w_nxt = S_DONE;
        else               w_cnt_nxt = r_cnt - 8'd1;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State, phase counters and configuration latched on accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pcnt   <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_npul   <= '0;
    end else if (bus.ena) begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      if (w_accept) begin
        r_period <= bus.period;
        r_high   <= bus.high_time;
        r_npul   <= bus.n_pulses;
      end
    end
  end

  // Feedback synchroniser and expected-value delay line. The line is fed with
  // the next stim value, so the stim flop plus the two sync flops give a total
  // of LAT cycles when the buffer is a plain wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_fb_prev <= 1'b0;
      r_dly     <= '0;
    end else if (bus.ena) begin
      r_sync    <= {r_sync[0], bus.fb_in};
      r_fb_prev <= w_fb;
      if (w_accept) r_dly <= DLY_FIRST;
      else          r_dly <= {r_dly[LAT-2:0], w_stim_nxt};
    end
  end

  // Registered outputs and saturating edge/error counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stim    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_edge    <= '0;
      r_err     <= '0;
    end else if (bus.ena) begin
      r_stim    <= w_stim_nxt;
      r_busy    <= (w_nxt == S_HIGH) || (w_nxt == S_LOW) || (w_nxt == S_FLUSH);
      r_done    <= (w_nxt == S_DONE);
      r_cfg_err <= w_reject;
      if (w_accept) begin
        r_edge <= '0;
        r_err  <= '0;
      end else if (w_active) begin
        if (w_rise && (r_edge != 8'hFF))                  r_edge <= r_edge + 8'd1;
        if ((w_fb != r_dly[LAT-1]) && (r_err != 8'hFF))   r_err  <= r_err + 8'd1;
      end
    end
  end

  assign bus.stim_out = r_stim;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.cfg_err  = r_cfg_err;
  assign bus.edge_cnt = r_edge;
  assign bus.err_cnt  = r_err;
endmodule

// File: doc/mr_latch_stim.md
MR_LATCH_STIM -- requirements
Module: mr_latch_stim

Interface
REQ-001 SHALL have parameter LAT, default 3: cycles from stim_out to synchronised feedback used by the compare, legal range 2..7.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port ena  input  1  clock enable; when 0 every register holds its value.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-006 SHALL have port stop  input  1  abort the running burst.
REQ-007 SHALL have port period  input  8  cycles per pulse, sampled on accepted start.
REQ-008 SHALL have port high_time  input  8  high cycles per pulse, sampled on accepted start.
REQ-009 SHALL have port n_pulses  input  8  pulses per burst; 0 means run until stop.
REQ-010 SHALL have port stim_out  output  1  registered drive to the analog buffer input pad.
REQ-011 SHALL have port fb_in  input  1  asynchronous buffered signal returned from the buffer output.
REQ-012 SHALL have port busy  output  1  high in HIGH, LOW and FLUSH.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a burst completes or aborts.
REQ-014 SHALL have port cfg_err  output  1  one-cycle pulse when start is rejected for illegal configuration.
REQ-015 SHALL have port edge_cnt  output  8  count of feedback rising edges in the current or last burst.
REQ-016 SHALL have port err_cnt  output  8  count of feedback/expected mismatch cycles.

Function
REQ-017 SHALL synchronise fb_in through two flops (fb_sync) before any use.
REQ-018 SHALL implement FSM states IDLE, HIGH, LOW, FLUSH, DONE.
REQ-019 SHALL accept start only in IDLE with period >= 2 and 1 <= high_time < period; accepting latches period, high_time and n_pulses, clears edge_cnt, err_cnt, the pulse counter and the delay line, and enters HIGH.
REQ-020 SHALL, on start in IDLE with illegal configuration, pulse cfg_err for one cycle and stay in IDLE.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL drive stim_out = 1 in HIGH and 0 in every other state, registered, so stim_out rises in the cycle after start is accepted.
REQ-023 SHALL remain in HIGH for high_time cycles, then in LOW for period - high_time cycles.
REQ-024 SHALL, at the end of LOW, increment the pulse counter; if n_pulses != 0 and the counter equals n_pulses, go to FLUSH, otherwise go to HIGH.
REQ-025 SHALL, with n_pulses = 0, wrap the 8-bit pulse counter freely and never leave HIGH/LOW except by stop.
REQ-026 SHALL, on stop in HIGH or LOW, go to FLUSH on the next edge, stim_out = 0 from that edge; stop has priority over the end-of-phase transitions in the same cycle; stop is ignored in IDLE, FLUSH and DONE.
REQ-027 SHALL hold FLUSH for LAT + 1 cycles, then enter DONE.
REQ-028 SHALL pulse done = 1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-029 SHALL delay stim_out by LAT cycles through a shift register (stim_dly) and, in HIGH, LOW and FLUSH, increment err_cnt in each cycle where fb_sync != stim_dly.
REQ-030 SHALL increment edge_cnt on each rising edge of fb_sync detected while busy.
REQ-031 SHALL saturate edge_cnt and err_cnt at 255 and hold both in IDLE until the next accepted start.
REQ-032 SHALL freeze all state, counters and outputs, including the synchroniser, while ena = 0, and resume without loss when ena returns to 1.

Reset
REQ-033 SHALL, on rst_n = 0, immediately force IDLE, stim_out = 0, busy = 0, done = 0, cfg_err = 0, edge_cnt = 0, err_cnt = 0, and clear the synchroniser, the delay line and all latched configuration.
REQ-034 SHALL, on reset asserted mid-burst, drop stim_out without completing the pulse and without asserting done.

Verification
REQ-035 SHALL cover: fb_in tied to stim_out, start with period=4, high_time=1, n_pulses=3 -> stim_out high 1 of every 4 cycles for 3 pulses, FLUSH 4 cycles, done pulse, edge_cnt=3, err_cnt=0.
REQ-036 SHALL cover: fb_in tied to 0, period=10, high_time=5, n_pulses=2 -> edge_cnt=0, err_cnt=10.
REQ-037 SHALL cover: start with period=5, high_time=5 -> cfg_err pulses once, busy stays 0; start with period=1 -> cfg_err pulses once, busy stays 0.
REQ-038 SHALL cover: n_pulses=0, period=2, high_time=1, run 600 cycles, stop asserted on the same cycle LOW ends -> enters FLUSH, not HIGH; edge_cnt saturates at 255; done pulses.
REQ-039 SHALL cover: ena=0 for 7 cycles mid-HIGH -> the HIGH phase resumes with its remaining cycles and the counters are unchanged.
REQ-040 SHALL cover: rst_n low mid-LOW, then start repeated during busy -> after reset all outputs are 0; the repeated start is ignored and the burst length is unchanged.
